// File: rtl/ram_pkg.sv
// Shared codes and helpers for the sized-access RAM controller.
// Holds the transfer size encodings, the FSM state type and the size lookup.
package ram_pkg;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    BYTE       = 2'b00,
    HALFWORD   = 2'b01,
    WORD       = 2'b10,
    DOUBLEWORD = 2'b11
  } type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10,
    DONE   = 2'b11
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] t);
    return 4'd1 << t;
  endfunction

endpackage

// File: rtl/ram_sized_access_ctrl_if.sv
// Request/response bundle between the CPU memory stage (master) and the RAM controller (slave).
// Handshake: master raises mv with request fields stable; slave answers with moc (err valid with it);
// master drops mv, slave clears moc on the following edge. dbg_state mirrors the controller FSM.
interface ram_sized_access_ctrl_if #(
  parameter int ADDR_W = 8
);
  import ram_pkg::*;

  logic              enable;
  logic              mv;
  logic              rw;
  logic [1:0]        type_data;
  logic              sign_ext;
  logic [ADDR_W-1:0] address;
  logic [63:0]       data_in;
  logic [63:0]       data_out;
  logic              moc;
  logic              err;
  logic              busy;
  state_e            dbg_state;

  modport master (
    output enable, mv, rw, type_data, sign_ext, address, data_in,
    input  data_out, moc, err, busy, dbg_state
  );

  modport slave (
    input  enable, mv, rw, type_data, sign_ext, address, data_in,
    output data_out, moc, err, busy, dbg_state
  );

endinterface

// File: rtl/ram_byte_array.sv
// DEPTH x 8 byte storage; lane i addresses addr+i for both the write enables and the read port.
// Contents are deliberately not reset.
module ram_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [7:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we[i]) mem[addr + ADDR_W'(i)] <= wdata[8*i +: 8];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[addr + ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/ram_sized_access_ctrl.sv
// Sized byte/half/word/double RAM access controller with programmable wait states,
// alignment/range checking, selectable byte order and optional sign extension.
module ram_sized_access_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1,
  parameter int BIG_ENDIAN  = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  ram_sized_access_ctrl_if.slave bus
);

  localparam int AW1 = ADDR_W + 1;

  state_e            state;
  logic [3:0]        cnt;
  logic              rw_q, sext_q, err_hold;
  logic [1:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       data_q;
  logic [63:0]       data_out_q;
  logic              moc_q, err_q, busy_q;

  logic [3:0]     size;
  logic [AW1-1:0] size_w, last_addr;
  logic           err_c;
  logic [7:0]     we;
  logic [63:0]    wdata_mem, rdata_mem, raw, read_value;
  logic           msb;

  assign size      = size_bytes(type_q);
  assign size_w    = AW1'(size);
  // One extra address bit so the last byte of an access can never wrap to zero.
  assign last_addr = {1'b0, addr_q} + size_w - AW1'(1);
  assign err_c     = (({1'b0, addr_q} & (size_w - AW1'(1))) != '0) | last_addr[ADDR_W];

  // Map the right-aligned value onto memory-order lanes and back.
  always_comb begin
    wdata_mem  = '0;
    raw        = '0;
    we         = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(size)) begin
        if (BIG_ENDIAN != 0) begin
          wdata_mem[8*i +: 8]                 = data_q[8*(int'(size)-1-i) +: 8];
          raw[8*(int'(size)-1-i) +: 8]        = rdata_mem[8*i +: 8];
        end else begin
          wdata_mem[8*i +: 8] = data_q[8*i +: 8];
          raw[8*i +: 8]       = rdata_mem[8*i +: 8];
        end
        if (state == ACCESS && rw_q == WRITE && !err_c) we[i] = 1'b1;
      end
    end
    msb        = raw[8*int'(size)-1];
    read_value = raw;
    for (int i = 0; i < 8; i++) begin
      if (i >= int'(size)) read_value[8*i +: 8] = {8{sext_q & msb}};
    end
  end

  ram_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (we),
    .addr  (addr_q),
    .wdata (wdata_mem),
    .rdata (rdata_mem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rw_q       <= 1'b0;
      sext_q     <= 1'b0;
      type_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      err_hold   <= 1'b0;
      data_out_q <= '0;
      moc_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          moc_q <= 1'b0;
          err_q <= 1'b0;
          cnt   <= '0;
          if (bus.mv && bus.enable) begin
            rw_q   <= bus.rw;
            type_q <= bus.type_data;
            sext_q <= bus.sign_ext;
            addr_q <= bus.address;
            data_q <= bus.data_in;
            busy_q <= 1'b1;
            state  <= (WAIT_STATES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'(WAIT_STATES - 1)) state <= ACCESS;
          else                            cnt   <= cnt + 4'd1;
        end
        ACCESS: begin
          err_hold <= err_c;
          if (!err_c && rw_q == READ) data_out_q <= read_value;
          state <= DONE;
        end
        DONE: begin
          // moc follows DONE by one edge, so it outlives DONE by one cycle.
          moc_q <= 1'b1;
          err_q <= err_hold;
          if (!bus.mv) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.moc       = moc_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state;

endmodule
